// File: rtl/mc_seq_ctrl_if.sv
// Control/bus bundle between the multi-cycle sequencer (master) and the RV32I
// datapath plus shared memory port (slave).
interface mc_seq_ctrl_if;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        mem_ready;
  logic        branch_taken;

  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic [1:0]  alu_src;
  logic [3:0]  alu_op;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        illegal;
  logic [31:0] instret;

  modport master (
    input  opcode, funct3, funct7, mem_ready, branch_taken,
    output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src,
           alu_op, reg_we, wb_sel, illegal, instret
  );

  modport slave (
    output opcode, funct3, funct7, mem_ready, branch_taken,
    input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src,
           alu_op, reg_we, wb_sel, illegal, instret
  );
endinterface

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV32I datapath with a
// retired-instruction counter. Define MC_ILLEGAL_TRAP_EN to trap on illegal ops.
module mc_seq_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  mc_seq_ctrl_if.master bus
);

`ifdef MC_ILLEGAL_TRAP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_e;
`endif

  typedef enum logic [2:0] {
    C_R, C_IALU, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_ILL
  } class_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  state_e      state_q;
  class_e      class_q, class_d;
  alu_op_e     alu_op_q, alu_op_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    class_d  = C_ILL;
    alu_op_d = ALU_ADD;
    case (bus.opcode)
      OP_R: begin
        class_d = C_R;
        case ({bus.funct7, bus.funct3})
          {F7_BASE, 3'b000}: alu_op_d = ALU_ADD;
          {F7_ALT,  3'b000}: alu_op_d = ALU_SUB;
          {F7_BASE, 3'b001}: alu_op_d = ALU_SLL;
          {F7_BASE, 3'b010}: alu_op_d = ALU_SLT;
          {F7_BASE, 3'b011}: alu_op_d = ALU_SLTU;
          {F7_BASE, 3'b100}: alu_op_d = ALU_XOR;
          {F7_BASE, 3'b101}: alu_op_d = ALU_SRL;
          {F7_ALT,  3'b101}: alu_op_d = ALU_SRA;
          {F7_BASE, 3'b110}: alu_op_d = ALU_OR;
          {F7_BASE, 3'b111}: alu_op_d = ALU_AND;
          default:           class_d  = C_ILL;
        endcase
      end
      OP_IALU: begin
        class_d = C_IALU;
        case (bus.funct3)
          3'b000: alu_op_d = ALU_ADD;
          3'b010: alu_op_d = ALU_SLT;
          3'b011: alu_op_d = ALU_SLTU;
          3'b100: alu_op_d = ALU_XOR;
          3'b110: alu_op_d = ALU_OR;
          3'b111: alu_op_d = ALU_AND;
          3'b001: begin
            if (bus.funct7 == F7_BASE) alu_op_d = ALU_SLL;
            else                       class_d  = C_ILL;
          end
          default: begin  // 3'b101: srli / srai share funct3
            if (bus.funct7 == F7_BASE)     alu_op_d = ALU_SRL;
            else if (bus.funct7 == F7_ALT) alu_op_d = ALU_SRA;
            else                           class_d  = C_ILL;
          end
        endcase
      end
      OP_LOAD:   class_d = C_LOAD;
      OP_STORE:  class_d = C_STORE;
      OP_BRANCH: begin
        class_d  = C_BRANCH;
        alu_op_d = ALU_SUB;
      end
      OP_JAL:    class_d = C_JAL;
      OP_JALR:   class_d = C_JALR;
      default:   class_d = C_ILL;
    endcase
  end

  // An illegal op in DECODE retires as a NOP only when it is not trapped.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_WB:     retire = 1'b1;
      S_EXEC:   retire = (class_q == C_BRANCH);
      S_MEM:    retire = bus.mem_ready && (class_q == C_STORE);
`ifndef MC_ILLEGAL_TRAP_EN
      S_DECODE: retire = (class_d == C_ILL);
`endif
      default:  retire = 1'b0;
    endcase
    instret_d = retire ? instret_q + 32'd1 : instret_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      class_q   <= C_ILL;
      alu_op_q  <= ALU_ADD;
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
      case (state_q)
        S_IDLE:  state_q <= S_FETCH;
        S_FETCH: if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          class_q  <= class_d;
          alu_op_q <= alu_op_d;
`ifdef MC_ILLEGAL_TRAP_EN
          state_q  <= (class_d == C_ILL) ? S_TRAP : S_EXEC;
`else
          state_q  <= (class_d == C_ILL) ? S_FETCH : S_EXEC;
`endif
        end
        S_EXEC: begin
          case (class_q)
            C_LOAD, C_STORE: state_q <= S_MEM;
            C_BRANCH:        state_q <= S_FETCH;
            default:         state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) state_q <= (class_q == C_LOAD) ? S_WB : S_FETCH;
        end
        S_WB:    state_q <= S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
        S_TRAP:  state_q <= S_TRAP;
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Controls depend only on state and the latched class, except the two
  // datapath handshakes that qualify writes (mem_ready, branch_taken).
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.addr_sel = 1'b0;
    bus.ir_we    = 1'b0;
    bus.pc_we    = 1'b0;
    bus.pc_src   = 2'b00;
    bus.alu_src  = 2'b00;
    bus.alu_op   = 4'b0000;
    bus.reg_we   = 1'b0;
    bus.wb_sel   = 2'b00;
    case (state_q)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.ir_we   = bus.mem_ready;
        bus.pc_we   = bus.mem_ready;
      end
      S_EXEC: begin
        bus.alu_op  = alu_op_q;
        bus.alu_src = (class_q == C_R || class_q == C_BRANCH) ? 2'b00 : 2'b01;
        case (class_q)
          C_BRANCH: begin
            bus.pc_we  = bus.branch_taken;
            bus.pc_src = 2'b01;
          end
          C_JAL: begin
            bus.pc_we  = 1'b1;
            bus.pc_src = 2'b01;
          end
          C_JALR: begin
            bus.pc_we  = 1'b1;
            bus.pc_src = 2'b10;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.mem_req  = 1'b1;
        bus.addr_sel = 1'b1;
        bus.mem_we   = (class_q == C_STORE);
      end
      S_WB: begin
        bus.reg_we = 1'b1;
        case (class_q)
          C_LOAD:         bus.wb_sel = 2'b01;
          C_JAL, C_JALR:  bus.wb_sel = 2'b10;
          default:        bus.wb_sel = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

`ifdef MC_ILLEGAL_TRAP_EN
  assign bus.illegal = (state_q == S_TRAP);
`else
  assign bus.illegal = 1'b0;
`endif

  assign bus.instret = instret_q;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Directed bench for mc_seq_ctrl: per-cycle control vectors checked at the
// falling edge against hand-derived expectations.
module tb_mc_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_instret = '0;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JL = 7'b1101111;
  localparam logic [6:0] OP_JR = 7'b1100111;

  mc_seq_ctrl_if bus ();

  mc_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src, alu_op, reg_we, wb_sel}
  logic [15:0] ctl;
  assign ctl = {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_we, bus.pc_we,
                bus.pc_src, bus.alu_src, bus.alu_op, bus.reg_we, bus.wb_sel};

  function automatic logic [15:0] mk(input logic req, input logic we,
      input logic asel, input logic irwe, input logic pcwe, input logic [1:0] psrc,
      input logic [1:0] asrc, input logic [3:0] op, input logic rwe,
      input logic [1:0] wbs);
    return {req, we, asel, irwe, pcwe, psrc, asrc, op, rwe, wbs};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ir(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    bus.funct7 = f7;
    bus.funct3 = f3;
    bus.opcode = op;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mem_ready = 1'b1;
    bus.branch_taken = 1'b0;
    set_ir(7'h00, 3'b000, OP_R);
    tick();
    tick();
    total += 3;
    if (ctl !== 16'h0) begin bad++; $display("FAIL reset_ctl got=%h want=0000", ctl); end
    if (bus.instret !== 32'd0) begin bad++; $display("FAIL reset_instret got=%0d want=0", bus.instret); end
    if (bus.illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", bus.illegal); end
    rst_n = 1'b1;
    #1;
    total++;
    if (ctl !== 16'h0) begin bad++; $display("FAIL idle_ctl got=%h want=0000", ctl); end
    tick();
  endtask

  task automatic test_alu();
    logic [16:0] ir [6];
    logic [5:0]  ex [6];
    logic [15:0] e;
    ir = '{{7'h00, 3'b000, OP_R}, {7'h20, 3'b000, OP_R}, {7'h00, 3'b011, OP_R},
           {7'h20, 3'b101, OP_I}, {7'h00, 3'b001, OP_I}, {7'h00, 3'b111, OP_I}};
    ex = '{6'b00_0000, 6'b00_0001, 6'b00_1001, 6'b01_0111, 6'b01_0101, 6'b01_0010};
    for (int k = 0; k < 6; k++) begin
      {bus.funct7, bus.funct3, bus.opcode} = ir[k];
      for (int i = 0; i < 4; i++) begin
        case (i)
          0:       e = mk(1, 0, 0, 1, 1, 2'b00, 2'b00, 4'h0, 0, 2'b00);
          1:       e = 16'h0;
          2:       e = mk(0, 0, 0, 0, 0, 2'b00, ex[k][5:4], ex[k][3:0], 0, 2'b00);
          default: e = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 1, 2'b00);
        endcase
        bus.mem_ready = 1'b1;
        bus.branch_taken = 1'b1;
        if (i == 2) bus.opcode = 7'h7f;
        #1;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL alu%0d cyc%0d got=%h want=%h", k, i, ctl, e); end
        tick();
      end
      exp_instret++;
      total++;
      if (bus.instret !== exp_instret) begin
        bad++; $display("FAIL alu%0d_instret got=%0d want=%0d", k, bus.instret, exp_instret);
      end
    end
  endtask

  task automatic test_load();
    logic [15:0] e [7];
    logic        rd [7];
    e = '{mk(1, 0, 0, 1, 1, 2'b00, 2'b00, 4'h0, 0, 2'b00), 16'h0,
          mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 4'h0, 0, 2'b00),
          mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 4'h0, 0, 2'b00),
          mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 4'h0, 0, 2'b00),
          mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 4'h0, 0, 2'b00),
          mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 1, 2'b01)};
    rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    set_ir(7'h00, 3'b010, OP_LD);
    bus.branch_taken = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = rd[i];
      if (i == 2) bus.opcode = 7'h7f;
      #1;
      total++;
      if (ctl !== e[i]) begin bad++; $display("FAIL lw cyc%0d got=%h want=%h", i, ctl, e[i]); end
      tick();
    end
    exp_instret++;
    total++;
    if (bus.instret !== exp_instret) begin
      bad++; $display("FAIL lw_instret got=%0d want=%0d", bus.instret, exp_instret);
    end
  endtask

  task automatic test_store();
    logic [15:0] e [5];
    logic        rd [5];
    e = '{mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0, 2'b00),
          mk(1, 0, 0, 1, 1, 2'b00, 2'b00, 4'h0, 0, 2'b00), 16'h0,
          mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 4'h0, 0, 2'b00),
          mk(1, 1, 1, 0, 0, 2'b00, 2'b00, 4'h0, 0, 2'b00)};
    rd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    set_ir(7'h00, 3'b010, OP_ST);
    bus.branch_taken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.mem_ready = rd[i];
      if (i == 3) bus.opcode = 7'h7f;
      #1;
      total++;
      if (ctl !== e[i]) begin bad++; $display("FAIL sw cyc%0d got=%h want=%h", i, ctl, e[i]); end
      tick();
    end
    exp_instret++;
    total++;
    if (bus.instret !== exp_instret) begin
      bad++; $display("FAIL sw_instret got=%0d want=%0d", bus.instret, exp_instret);
    end
  endtask

  task automatic test_branch();
    logic [15:0] e;
    for (int k = 0; k < 2; k++) begin
      set_ir(7'h00, 3'b000, OP_BR);
      for (int i = 0; i < 3; i++) begin
        case (i)
          0:       e = mk(1, 0, 0, 1, 1, 2'b00, 2'b00, 4'h0, 0, 2'b00);
          1:       e = 16'h0;
          default: e = mk(0, 0, 0, 0, (k == 0), 2'b01, 2'b00, 4'h1, 0, 2'b00);
        endcase
        bus.mem_ready = 1'b1;
        bus.branch_taken = (k == 0);
        if (i == 2) bus.opcode = 7'h7f;
        #1;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL beq%0d cyc%0d got=%h want=%h", k, i, ctl, e); end
        tick();
      end
      exp_instret++;
      total++;
      if (bus.instret !== exp_instret) begin
        bad++; $display("FAIL beq%0d_instret got=%0d want=%0d", k, bus.instret, exp_instret);
      end
    end
  endtask

  task automatic test_jump();
    logic [15:0] e;
    for (int k = 0; k < 2; k++) begin
      set_ir(7'h00, 3'b000, (k == 0) ? OP_JL : OP_JR);
      for (int i = 0; i < 4; i++) begin
        case (i)
          0:       e = mk(1, 0, 0, 1, 1, 2'b00, 2'b00, 4'h0, 0, 2'b00);
          1:       e = 16'h0;
          2:       e = mk(0, 0, 0, 0, 1, (k == 0) ? 2'b01 : 2'b10, 2'b01, 4'h0, 0, 2'b00);
          default: e = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 1, 2'b10);
        endcase
        bus.mem_ready = 1'b1;
        bus.branch_taken = 1'b0;
        if (i == 2) bus.opcode = 7'h7f;
        #1;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL jump%0d cyc%0d got=%h want=%h", k, i, ctl, e); end
        tick();
      end
      exp_instret++;
      total++;
      if (bus.instret !== exp_instret) begin
        bad++; $display("FAIL jump%0d_instret got=%0d want=%0d", k, bus.instret, exp_instret);
      end
    end
  endtask

`ifdef MC_ILLEGAL_TRAP_EN
  task automatic test_illegal();
    set_ir(7'h7f, 3'b111, 7'b1111111);
    bus.mem_ready = 1'b1;
    bus.branch_taken = 1'b0;
    #1;
    total++;
    if (ctl !== mk(1, 0, 0, 1, 1, 2'b00, 2'b00, 4'h0, 0, 2'b00)) begin
      bad++; $display("FAIL ill_fetch got=%h", ctl);
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      total += 2;
      if (bus.illegal !== 1'b1) begin bad++; $display("FAIL trap%0d_illegal got=%b want=1", i, bus.illegal); end
      if (ctl !== 16'h0) begin bad++; $display("FAIL trap%0d_ctl got=%h want=0000", i, ctl); end
      tick();
    end
    total++;
    if (bus.instret !== exp_instret) begin
      bad++; $display("FAIL trap_instret got=%0d want=%0d", bus.instret, exp_instret);
    end
    rst_n = 1'b0;
    exp_instret = '0;
    #1;
    total += 2;
    if (bus.illegal !== 1'b0) begin bad++; $display("FAIL trap_clear got=%b want=0", bus.illegal); end
    if (bus.instret !== 32'd0) begin bad++; $display("FAIL trap_rst_instret got=%0d want=0", bus.instret); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask
`else
  task automatic test_illegal();
    logic [16:0] ir [4];
    logic [15:0] e;
    ir = '{{7'h01, 3'b000, OP_R}, {7'h20, 3'b001, OP_I},
           {7'h01, 3'b101, OP_I}, {7'h00, 3'b000, 7'b1111111}};
    for (int k = 0; k < 4; k++) begin
      {bus.funct7, bus.funct3, bus.opcode} = ir[k];
      for (int i = 0; i < 3; i++) begin
        case (i)
          0:       e = mk(1, 0, 0, 1, 1, 2'b00, 2'b00, 4'h0, 0, 2'b00);
          1:       e = 16'h0;
          default: e = mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0, 2'b00);
        endcase
        bus.mem_ready = (i != 2);
        bus.branch_taken = 1'b0;
        #1;
        total++;
        if (ctl !== e) begin bad++; $display("FAIL nop%0d cyc%0d got=%h want=%h", k, i, ctl, e); end
        tick();
      end
      exp_instret++;
      total += 2;
      if (bus.instret !== exp_instret) begin
        bad++; $display("FAIL nop%0d_instret got=%0d want=%0d", k, bus.instret, exp_instret);
      end
      if (bus.illegal !== 1'b0) begin bad++; $display("FAIL nop%0d_illegal got=%b want=0", k, bus.illegal); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [15:0] f_wait;
    f_wait = mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 4'h0, 0, 2'b00);
    bus.mem_ready = 1'b0;
    #1;
    total++;
    if (ctl !== f_wait) begin bad++; $display("FAIL midf_pre got=%h want=%h", ctl, f_wait); end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_instret = '0;
    #1;
    total += 2;
    if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL midf_req got=%b want=0", bus.mem_req); end
    if (bus.instret !== 32'd0) begin bad++; $display("FAIL midf_instret got=%0d want=0", bus.instret); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (ctl !== 16'h0) begin bad++; $display("FAIL midf_idle got=%h want=0000", ctl); end
    tick();
    #1;
    total++;
    if (ctl !== f_wait) begin bad++; $display("FAIL midf_refetch got=%h want=%h", ctl, f_wait); end
    // Walk a load into MEM, then pull reset while the request is outstanding.
    set_ir(7'h00, 3'b010, OP_LD);
    bus.mem_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.mem_ready = 1'b0;
    #1;
    total++;
    if (ctl !== mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 4'h0, 0, 2'b00)) begin
      bad++; $display("FAIL midm_pre got=%h", ctl);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (ctl !== 16'h0) begin bad++; $display("FAIL midm_drop got=%h want=0000", ctl); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_jump();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_seq_ctrl.md
# mc_seq_ctrl

Multi-cycle sequencing controller for the RV32I integer datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives ALU, register-file, PC and memory-port controls on each step, so a single shared memory port and a single ALU can serve the whole instruction. It sits between the instruction register and the datapath, replacing per-cycle combinational decode. It also keeps a retired-instruction counter.

## Interface
- No parameters.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `opcode` in 7: IR[6:0]; sampled in DECODE only.
- `funct3` in 3: IR[14:12]; sampled in DECODE only.
- `funct7` in 7: IR[31:25]; sampled in DECODE only.
- `mem_ready` in 1: the memory port completes the current request this cycle.
- `branch_taken` in 1: branch compare result from the datapath; valid in EXEC.
- `mem_req` out 1: memory request is active.
- `mem_we` out 1: the memory request is a write.
- `addr_sel` out 1: memory address source; 0 = PC, 1 = ALU result register.
- `ir_we` out 1: load IR and the old-PC register.
- `pc_we` out 1: write PC.
- `pc_src` out 2: PC source; 00 = PC+4, 01 = old_pc+imm, 10 = {alu[31:1],0}.
- `alu_src` out 2: ALU B operand; 00 = rs2, 01 = imm.
- `alu_op` out 4: ALU operation.
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu.
- `reg_we` out 1: register-file write.
- `wb_sel` out 2: write-back source; 00 = ALU, 01 = memory data, 10 = old_pc+4.
- `illegal` out 1: sticky illegal-instruction flag.
- `instret` out 32: retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- All control outputs are combinational from the state and an instruction class latched in DECODE. Outputs never depend on the IR outside DECODE.
- **Classes:** R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, ILL.
- **ILL conditions:**
  - an unknown opcode;
  - an R-type {funct7,funct3} outside the ten defined combinations;
  - slli with funct7≠0;
  - srli/srai with funct7 ∉ {0000000, 0100000}.
- **alu_op mapping:** R and I-ALU per the encoding above. srai and sub use funct7=0100000. LOAD, STORE, JAL and JALR use add; BRANCH uses sub.
- **IDLE:** all outputs 0; goes to FETCH unconditionally.
- **FETCH:** mem_req=1, addr_sel=0.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=00; go to DECODE.
  - Otherwise hold with outputs stable.
- **DECODE:** latch the class and alu_op; go to EXEC. If the class is ILL, go to TRAP (the macro changes this; see Configuration).
- **EXEC:** alu_src=01 for all classes except R and BRANCH.
  - R, I-ALU, JAL, JALR go to WB.
  - LOAD and STORE go to MEM.
  - BRANCH: pc_we=branch_taken, pc_src=01; go to FETCH.
  - JAL: pc_we=1, pc_src=01.
  - JALR: pc_we=1, pc_src=10.
- **MEM:** mem_req=1, addr_sel=1, mem_we=STORE.
  - Hold until mem_ready.
  - On mem_ready, LOAD goes to WB and STORE goes to FETCH.
- **WB:** reg_we=1; go to FETCH.
  - wb_sel = 01 for LOAD.
  - wb_sel = 10 for JAL and JALR.
  - wb_sel = 00 otherwise.
- **Retire:** instret increments by 1 on each of these transitions:
  - WB→FETCH;
  - EXEC→FETCH for BRANCH;
  - MEM→FETCH for STORE.
  - It wraps from 0xFFFFFFFF to 0.
- **TRAP:** all outputs 0 except illegal=1. TRAP is terminal until reset.

## Timing
- Reset values: state=IDLE, every output 0, instret=0, illegal=0.
- Reset is asynchronous, so outputs fall as soon as rst_n asserts, including mid-FETCH and mid-MEM. An in-flight memory request is abandoned; the memory must tolerate mem_req dropping.
- After release: 1 cycle in IDLE, then FETCH.
- Zero-wait-state latency (mem_ready=1 in the first cycle of each request):
  - R / I-ALU / JAL / JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Each cycle with mem_ready=0 in FETCH or MEM adds one cycle.
- mem_ready is ignored in any state without mem_req.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined: ILL goes DECODE→TRAP; illegal=1 from the following cycle.
- `MC_ILLEGAL_TRAP_EN` undefined:
  - ILL executes as a NOP: DECODE→FETCH, no writes, instret increments.
  - illegal is tied to 0 and the TRAP state is not built.

## Test plan
- **Reset then add** x3=x1+x2, mem_ready=1 → IDLE, FETCH, DECODE, EXEC, WB. In WB: reg_we=1, wb_sel=00, alu_op=0000. instret becomes 1.
- **lw** with mem_ready low for 2 MEM cycles → MEM lasts 3 cycles with mem_req=1, addr_sel=1, mem_we=0. Then WB with wb_sel=01. Total 7 cycles.
- **beq** with branch_taken=1 and then 0 → EXEC gives pc_we=1, pc_src=01 the first time and pc_we=0 the second. No reg_we either time. instret increments both times.
- **jalr** → EXEC: pc_we=1, pc_src=10, alu_src=01. WB: wb_sel=10, reg_we=1.
- **Opcode 7'b1111111** → with the macro: illegal=1 and stuck; rst_n low clears it. Without the macro: NOP, instret increments.
- **Reset mid-FETCH** while mem_ready=0 → mem_req=0 immediately. After release, mem_req=1 again after exactly 1 IDLE cycle.
